alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Issue controller for the 4-bit ALU datapath: sum, complement, shift right/left, compare-carry, compare-negative and load units, selected by the 3-bit ALU result mux.
- Accepts one instruction per valid/ready handshake (opcode + operand) and drives the mux opcode and ALU operands.
- Waits a configurable ALU latency, then writes the mux result into an accumulator or a compare register.
- Sits between the instruction source (testbench/top FSM) and the ALU + mux.

Parameters:
- WIDTH, 4, datapath width of operands, accumulator and ALU result.
- ALU_LATENCY, 1, cycles between operand/opcode presentation and a valid final_result; legal range 0..7.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction available.
- instr_opcode  input  3  ALU operation code, same encoding as the ALU result mux.
- instr_operand  input  WIDTH  operand B / load value.
- instr_ready  output  1  controller can accept an instruction.
- alu_opcode  output  3  drives the mux opcode.
- alu_a  output  WIDTH  operand A, always the accumulator.
- alu_b  output  WIDTH  operand B, the captured operand.
- alu_result  input  WIDTH  the mux's final_result.
- acc  output  WIDTH  accumulator contents.
- cmp_flags  output  2  bit0 = compare-carry result, bit1 = compare-negative result; each bit is the LSB of the respective result.
- result_valid  output  1  one-cycle pulse when writeback completes.
- illegal_op  output  1  sticky error, set by opcode 3'h6.
- zero_flag  output  1  present only with ALU_SEQ_ZERO_FLAG_EN.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE; acc=0, cmp_flags=0, alu_opcode=0, alu_b=0, result_valid=0, illegal_op=0, zero_flag=1, wait counter=0.
  - Reset mid-operation aborts the instruction with no writeback.
- Opcode map:
  - 0 sum, 1 complement, 2 shift right, 3 shift left → write acc.
  - 4 compc → write cmp_flags[0]; 5 compn → write cmp_flags[1]; acc unchanged for both.
  - 7 load → write acc.
  - 6 reserved.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready: capture opcode into alu_opcode and operand into alu_b.
  - If opcode==6: set illegal_op, stay IDLE, no result_valid; else go to ISSUE.
- ISSUE:
  - Operands and opcode stable on the ALU ports; load counter with ALU_LATENCY.
  - Go to WB if ALU_LATENCY==0, else WAIT.
- WAIT: decrement counter; when counter reaches 1, go to WB.
- WB:
  - Sample alu_result combinationally into the destination register per the opcode map.
  - result_valid=1 for this cycle only; return to IDLE.
- instr_ready=0 in ISSUE, WAIT and WB. An instr_valid held during those states is not consumed; it is accepted in the first IDLE cycle.
- Latency: handshake cycle N → result_valid at cycle N+2+ALU_LATENCY. Throughput: one instruction per ALU_LATENCY+3 cycles.
- alu_opcode and alu_b hold their values between instructions (no glitch to 0).
- Width rules:
  - Results are taken as WIDTH bits; no extension or truncation is performed by the controller.
  - Wrap-around of sum is the ALU's responsibility.
- illegal_op clears only on reset.
- Back-to-back legal instructions see the updated acc as alu_a, because writeback precedes the next IDLE.

Optional Feature:
- Macro ALU_SEQ_ZERO_FLAG_EN.
- Defined:
  - zero_flag port exists; registered, updated in WB for acc-writing opcodes only.
  - zero_flag = (written value == 0); reset 1.
- Undefined: port and logic absent; everything else identical.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams: OP_SUM=0, OP_CPL=1, OP_SHR=2, OP_SHL=3, OP_CMPC=4, OP_CMPN=5, OP_RSVD=6, OP_LOAD=7.
  - state encoding: IDLE=0, ISSUE=1, WAIT=2, WB=3.
  - helper function is_acc_dest(opcode).
- One natural sub-module: alu_seq_wait_counter, a 3-bit loadable down-counter with a done output.
- FSM and writeback stay in the top.

Test Plan:
- Reset, then load 4'hA (op 7) with ALU model returning the operand → result_valid at handshake+3 (ALU_LATENCY=1); acc=4'hA, cmp_flags=0.
- acc=4'hA, sum operand 4'h9, model returns 4'h3 → acc=4'h3, one-cycle result_valid, instr_ready low for 3 cycles.
- Op 4 with model result 4'h1, then op 5 with 4'h0 → cmp_flags=2'b01; acc unchanged.
- Op 6 → illegal_op=1, no result_valid, instr_ready stays 1; the next legal op completes normally and illegal_op stays 1.
- Reset asserted in WAIT with ALU_LATENCY=3 → no writeback, acc=0, state IDLE the next cycle.
- Both builds:
  - With ALU_SEQ_ZERO_FLAG_EN: load 0 → zero_flag=1, then load 4'h5 → 0.
  - Without the macro: the build has no zero_flag port.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and destination decode for the ALU issue sequencer.
// Build option ALU_SEQ_ZERO_FLAG_EN is handled in the interface and the top, not here.
package alu_seq_pkg;

    localparam int CNT_W = 3;

    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_CPL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_CMPC = 3'd4;
    localparam logic [2:0] OP_CMPN = 3'd5;
    localparam logic [2:0] OP_RSVD = 3'd6;
    localparam logic [2:0] OP_LOAD = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    // True for opcodes whose mux result lands in the accumulator.
    function automatic logic is_acc_dest(input logic [2:0] op);
        case (op)
            OP_SUM, OP_CPL, OP_SHR, OP_SHL, OP_LOAD: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and status bundle between the sequencer (slave) and its environment (master).
// zero_flag exists only when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_seq_if #(
    parameter int WIDTH = 4
) ();
    import alu_seq_pkg::*;

    // Instruction handshake: a transfer happens on a rising edge where instr_valid and
    // instr_ready are both high; the source holds opcode/operand stable while valid is high.
    logic             instr_valid;
    logic [2:0]       instr_opcode;
    logic [WIDTH-1:0] instr_operand;
    logic             instr_ready;

    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic [WIDTH-1:0] acc;
    logic [1:0]       cmp_flags;
    logic             result_valid;
    logic             illegal_op;
    state_t           dbg_state;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic             zero_flag;

    modport slave (
        input  instr_valid, instr_opcode, instr_operand, alu_result,
        output instr_ready, alu_opcode, alu_a, alu_b, acc, cmp_flags,
               result_valid, illegal_op, dbg_state, zero_flag
    );

    modport master (
        output instr_valid, instr_opcode, instr_operand, alu_result,
        input  instr_ready, alu_opcode, alu_a, alu_b, acc, cmp_flags,
               result_valid, illegal_op, dbg_state, zero_flag
    );
`else
    modport slave (
        input  instr_valid, instr_opcode, instr_operand, alu_result,
        output instr_ready, alu_opcode, alu_a, alu_b, acc, cmp_flags,
               result_valid, illegal_op, dbg_state
    );

    modport master (
        output instr_valid, instr_opcode, instr_operand, alu_result,
        input  instr_ready, alu_opcode, alu_a, alu_b, acc, cmp_flags,
               result_valid, illegal_op, dbg_state
    );
`endif

endinterface

// File: rtl/alu_sequencer_wait_counter.sv
// Loadable 3-bit down-counter timing the ALU latency; done marks the last wait cycle.
module alu_seq_wait_counter
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller for the 4-bit ALU: accepts one instruction, waits ALU_LATENCY, writes back.
// Optional zero_flag output is built when ALU_SEQ_ZERO_FLAG_EN is defined.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(ALU_LATENCY);

    state_t           state_q;
    logic [2:0]       opcode_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [1:0]       cmp_q;
    logic             ready_q;
    logic             valid_q;
    logic             illegal_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic             zero_q;
`endif

    logic cnt_load_d;
    logic cnt_dec_d;
    logic cnt_done;

    assign cnt_load_d = (state_q == ISSUE);
    assign cnt_dec_d  = (state_q == WAIT);

    alu_seq_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_d),
        .load_val_i (LAT),
        .dec_i      (cnt_dec_d),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            opcode_q  <= OP_SUM;
            b_q       <= '0;
            acc_q     <= '0;
            cmp_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q    <= 1'b1;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.instr_valid && ready_q) begin
                        opcode_q <= bus.instr_opcode;
                        b_q      <= bus.instr_operand;
                        // Reserved opcode is dropped on the spot; the sequencer stays ready.
                        if (bus.instr_opcode == OP_RSVD) begin
                            illegal_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (LAT == '0) begin
                        state_q <= WB;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_done) begin
                        state_q <= WB;
                        valid_q <= 1'b1;
                    end
                end
                WB: begin
                    if (is_acc_dest(opcode_q)) begin
                        acc_q <= bus.alu_result;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        zero_q <= (bus.alu_result == '0);
`endif
                    end else if (opcode_q == OP_CMPC) begin
                        cmp_q[0] <= bus.alu_result[0];
                    end else if (opcode_q == OP_CMPN) begin
                        cmp_q[1] <= bus.alu_result[0];
                    end
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.instr_ready  = ready_q;
    assign bus.alu_opcode   = opcode_q;
    assign bus.alu_a        = acc_q;
    assign bus.alu_b        = b_q;
    assign bus.acc          = acc_q;
    assign bus.cmp_flags    = cmp_q;
    assign bus.result_valid = valid_q;
    assign bus.illegal_op   = illegal_q;
    assign bus.dbg_state    = state_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign bus.zero_flag    = zero_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table on a latency-1 instance, hand sequences
// for held valid and a mid-WAIT reset on a latency-3 instance.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] opd;
        logic [W-1:0] res;
        logic [W-1:0] exp_acc;
        logic [1:0]   exp_cmp;
        logic         exp_ill;
        logic         exp_zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [W-1:0] model_acc;
    logic [W-1:0] exp_q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus1 ();
    alu_seq_if #(.WIDTH(W)) bus3 ();

    alu_sequencer #(.WIDTH(W), .ALU_LATENCY(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    alu_sequencer #(.WIDTH(W), .ALU_LATENCY(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(bus1.instr_ready), 32'd1);
        bus1.instr_valid   = 1'b1;
        bus1.instr_opcode  = v.op;
        bus1.instr_operand = v.opd;
        bus1.alu_result    = v.res;
        @(negedge clk);
        bus1.instr_valid = 1'b0;
        check({tag, " alu_opcode"}, 32'(bus1.alu_opcode), 32'(v.op));
        check({tag, " alu_b"}, 32'(bus1.alu_b), 32'(v.opd));
        if (v.op == OP_RSVD) begin
            for (int i = 0; i < 3; i++) begin
                check({tag, " ill_ready"}, 32'(bus1.instr_ready), 32'd1);
                check({tag, " ill_no_valid"}, 32'(bus1.result_valid), 32'd0);
                @(negedge clk);
            end
        end else begin
            exp_q.push_back(v.exp_acc);
            check({tag, " alu_a"}, 32'(bus1.alu_a), 32'(model_acc));
            check({tag, " ready_busy"}, 32'(bus1.instr_ready), 32'd0);
            cyc = 1;
            while (bus1.result_valid !== 1'b1 && cyc < 12) begin
                @(negedge clk);
                cyc++;
                check({tag, " ready_busy"}, 32'(bus1.instr_ready), 32'd0);
            end
            check({tag, " latency"}, 32'(cyc), 32'd3);
            @(negedge clk);
            check({tag, " valid_pulse"}, 32'(bus1.result_valid), 32'd0);
            check({tag, " ready_back"}, 32'(bus1.instr_ready), 32'd1);
            if (exp_q.size() > 0) begin
                check({tag, " acc_sb"}, 32'(bus1.acc), 32'(exp_q.pop_front()));
            end
        end
        check({tag, " acc"}, 32'(bus1.acc), 32'(v.exp_acc));
        check({tag, " cmp"}, 32'(bus1.cmp_flags), 32'(v.exp_cmp));
        check({tag, " illegal"}, 32'(bus1.illegal_op), 32'(v.exp_ill));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check({tag, " zero"}, 32'(bus1.zero_flag), 32'(v.exp_zero));
`endif
        model_acc = v.exp_acc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        int second_at;
        //          op     opd    res    acc    cmp    ill   zero
        vecs[0]  = '{3'd7, 4'hA, 4'hA, 4'hA, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 4'h9, 4'h3, 4'h3, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{3'd4, 4'h2, 4'h1, 4'h3, 2'b01, 1'b0, 1'b0};
        vecs[3]  = '{3'd5, 4'h5, 4'h0, 4'h3, 2'b01, 1'b0, 1'b0};
        vecs[4]  = '{3'd5, 4'h1, 4'hF, 4'h3, 2'b11, 1'b0, 1'b0};
        vecs[5]  = '{3'd4, 4'h7, 4'hE, 4'h3, 2'b10, 1'b0, 1'b0};
        vecs[6]  = '{3'd6, 4'h3, 4'h0, 4'h3, 2'b10, 1'b1, 1'b0};
        vecs[7]  = '{3'd1, 4'h0, 4'hC, 4'hC, 2'b10, 1'b1, 1'b0};
        vecs[8]  = '{3'd2, 4'h4, 4'h6, 4'h6, 2'b10, 1'b1, 1'b0};
        vecs[9]  = '{3'd3, 4'h1, 4'h8, 4'h8, 2'b10, 1'b1, 1'b0};
        vecs[10] = '{3'd7, 4'h0, 4'h0, 4'h0, 2'b10, 1'b1, 1'b1};
        vecs[11] = '{3'd4, 4'h0, 4'h1, 4'h0, 2'b11, 1'b1, 1'b1};
        vecs[12] = '{3'd7, 4'h5, 4'h5, 4'h5, 2'b11, 1'b1, 1'b0};

        rst1 = 1'b1;
        rst3 = 1'b1;
        bus1.instr_valid = 1'b0; bus1.instr_opcode = 3'd0; bus1.instr_operand = '0; bus1.alu_result = '0;
        bus3.instr_valid = 1'b0; bus3.instr_opcode = 3'd0; bus3.instr_operand = '0; bus3.alu_result = '0;
        model_acc = '0;
        repeat (2) @(negedge clk);

        check("rst acc", 32'(bus1.acc), 32'd0);
        check("rst cmp", 32'(bus1.cmp_flags), 32'd0);
        check("rst alu_opcode", 32'(bus1.alu_opcode), 32'd0);
        check("rst alu_b", 32'(bus1.alu_b), 32'd0);
        check("rst valid", 32'(bus1.result_valid), 32'd0);
        check("rst illegal", 32'(bus1.illegal_op), 32'd0);
        check("rst ready", 32'(bus1.instr_ready), 32'd1);
        check("rst state", 32'(bus1.dbg_state), 32'(IDLE));
        check("rst3 acc", 32'(bus3.acc), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("rst zero", 32'(bus1.zero_flag), 32'd1);
`endif
        rst1 = 1'b0;
        rst3 = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Valid held high through a whole transaction: second copy accepted on the first IDLE cycle.
        @(negedge clk);
        bus1.instr_valid = 1'b1; bus1.instr_opcode = OP_LOAD; bus1.instr_operand = 4'h2; bus1.alu_result = 4'h2;
        pulses = 0;
        second_at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 4) bus1.instr_valid = 1'b0;
            if (bus1.result_valid === 1'b1) begin
                pulses++;
                if (pulses == 2) second_at = i;
            end
        end
        check("held pulses", 32'(pulses), 32'd2);
        check("held second_at", 32'(second_at), 32'd6);
        check("held acc", 32'(bus1.acc), 32'h2);
        check("held illegal sticky", 32'(bus1.illegal_op), 32'd1);

        // Latency-3 instance: full transaction, then reset while in WAIT.
        @(negedge clk);
        bus3.instr_valid = 1'b1; bus3.instr_opcode = OP_LOAD; bus3.instr_operand = 4'h6; bus3.alu_result = 4'h6;
        @(negedge clk);
        bus3.instr_valid = 1'b0;
        cyc = 1;
        while (bus3.result_valid !== 1'b1 && cyc < 15) begin
            @(negedge clk);
            cyc++;
        end
        check("l3 latency", 32'(cyc), 32'd5);
        @(negedge clk);
        check("l3 acc", 32'(bus3.acc), 32'h6);
        check("l3 state idle", 32'(bus3.dbg_state), 32'(IDLE));

        bus3.instr_valid = 1'b1; bus3.instr_opcode = OP_LOAD; bus3.instr_operand = 4'hB; bus3.alu_result = 4'hB;
        @(negedge clk);
        bus3.instr_valid = 1'b0;
        check("l3 issue", 32'(bus3.dbg_state), 32'(ISSUE));
        @(negedge clk);
        check("l3 wait", 32'(bus3.dbg_state), 32'(WAIT));
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        check("abort state", 32'(bus3.dbg_state), 32'(IDLE));
        check("abort acc", 32'(bus3.acc), 32'd0);
        check("abort ready", 32'(bus3.instr_ready), 32'd1);
        check("abort alu_b", 32'(bus3.alu_b), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus3.result_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        check("abort no wb", 32'(pulses), 32'd0);
        check("abort acc hold", 32'(bus3.acc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
